// File: rtl/cpu_8bit_sequencer.sv
// Bus initiator for the 8-bit CPU datapath. It runs one instruction at a time
// through SETUP/STROBE/HOLD and produces the register strobes, the ALU controls
// and the shared-bus drive. It also captures read data from the bus.
module cpu_8bit_sequencer #(
    localparam int unsigned DATA_W = 8,
    localparam int unsigned OPC_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [2:0]        i_instr_op,
    input  logic [DATA_W-1:0] i_instr_data,
    input  logic [OPC_W-1:0]  i_instr_alu_op,
    input  logic              i_instr_cin,
    output logic              o_a_wrtn,
    output logic              o_a_rdn,
    output logic              o_b_wrtn,
    output logic              o_b_rdn,
    output logic [OPC_W-1:0]  o_alu_opcode,
    output logic              o_cin,
    output logic              o_alu_sel,
    output logic              o_alu_flag_sel,
    inout  wire  [DATA_W-1:0] io_data_bus,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_err
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;

    typedef enum logic [2:0] {
        OP_WR_A     = 3'd0,
        OP_WR_B     = 3'd1,
        OP_RD_A     = 3'd2,
        OP_RD_B     = 3'd3,
        OP_ALU_RD   = 3'd4,
        OP_ALU_WA   = 3'd5,
        OP_FLAGS_RD = 3'd6,
        OP_ILLEGAL  = 3'd7
    } op_e;

    state_e            r_state;
    state_e            w_state_next;
    op_e               r_op;
    op_e               w_op_next;
    op_e               w_in_op;
    logic [DATA_W-1:0] r_data;
    logic [OPC_W-1:0]  r_alu_opcode;
    logic              r_cin;
    logic              r_instr_ready;
    logic              r_a_wrtn, r_a_rdn, r_b_wrtn, r_b_rdn;
    logic              r_alu_sel, r_alu_flag_sel;
    logic              r_bus_oe;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_err;

    logic w_accept, w_illegal, w_start, w_in_alu, w_active, w_capture;
    logic w_a_wrtn, w_a_rdn, w_b_wrtn, w_b_rdn, w_alu_sel, w_flag_sel, w_bus_oe;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus next values of the registered controls, derived from the next state
    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_in_op      = op_e'(i_instr_op);
        w_accept     = i_instr_valid && (r_state == S_IDLE);
        w_illegal    = w_accept && (w_in_op == OP_ILLEGAL);
        w_start      = w_accept && !w_illegal;
        w_in_alu     = (w_in_op == OP_ALU_RD) || (w_in_op == OP_ALU_WA) ||
                       (w_in_op == OP_FLAGS_RD);

        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_SETUP;
            S_SETUP:  w_state_next = S_STROBE;
            S_STROBE: w_state_next = S_HOLD;
            S_HOLD:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase

        if (w_start) w_op_next = w_in_op;

        w_active   = (w_state_next != S_IDLE);
        w_a_wrtn   = !((w_state_next == S_STROBE) &&
                       ((w_op_next == OP_WR_A) || (w_op_next == OP_ALU_WA)));
        w_b_wrtn   = !((w_state_next == S_STROBE) && (w_op_next == OP_WR_B));
        w_a_rdn    = !(((w_state_next == S_SETUP) || (w_state_next == S_STROBE)) &&
                       (w_op_next == OP_RD_A));
        w_b_rdn    = !(((w_state_next == S_SETUP) || (w_state_next == S_STROBE)) &&
                       (w_op_next == OP_RD_B));
        w_alu_sel  = w_active && ((w_op_next == OP_ALU_RD) || (w_op_next == OP_ALU_WA) ||
                                  (w_op_next == OP_FLAGS_RD));
        w_flag_sel = w_active && (w_op_next == OP_FLAGS_RD);
        w_bus_oe   = w_active && ((w_op_next == OP_WR_A) || (w_op_next == OP_WR_B));
        w_capture  = (r_state == S_STROBE) &&
                     ((r_op == OP_RD_A) || (r_op == OP_RD_B) ||
                      (r_op == OP_ALU_RD) || (r_op == OP_FLAGS_RD));
    end

    // Instruction register, registered controls and response capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op           <= OP_WR_A;
            r_data         <= '0;
            r_alu_opcode   <= '0;
            r_cin          <= 1'b0;
            r_instr_ready  <= 1'b1;
            r_a_wrtn       <= 1'b1;
            r_a_rdn        <= 1'b1;
            r_b_wrtn       <= 1'b1;
            r_b_rdn        <= 1'b1;
            r_alu_sel      <= 1'b0;
            r_alu_flag_sel <= 1'b0;
            r_bus_oe       <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_err          <= 1'b0;
        end else begin
            r_op <= w_op_next;
            if (w_start) r_data <= i_instr_data;
            if (w_start && w_in_alu) begin
                r_alu_opcode <= i_instr_alu_op;
                r_cin        <= i_instr_cin;
            end
            r_instr_ready  <= (w_state_next == S_IDLE);
            r_a_wrtn       <= w_a_wrtn;
            r_a_rdn        <= w_a_rdn;
            r_b_wrtn       <= w_b_wrtn;
            r_b_rdn        <= w_b_rdn;
            r_alu_sel      <= w_alu_sel;
            r_alu_flag_sel <= w_flag_sel;
            r_bus_oe       <= w_bus_oe;
            r_rsp_valid    <= w_capture;
            if (w_capture) r_rsp_data <= io_data_bus;
            r_err          <= w_illegal;
        end
    end

    assign io_data_bus    = r_bus_oe ? r_data : {DATA_W{1'bz}};
    assign o_instr_ready  = r_instr_ready;
    assign o_a_wrtn       = r_a_wrtn;
    assign o_a_rdn        = r_a_rdn;
    assign o_b_wrtn       = r_b_wrtn;
    assign o_b_rdn        = r_b_rdn;
    assign o_alu_opcode   = r_alu_opcode;
    assign o_cin          = r_cin;
    assign o_alu_sel      = r_alu_sel;
    assign o_alu_flag_sel = r_alu_flag_sel;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_err          = r_err;

endmodule
